key_schedule_stream: RTL and testbench

Parametrised, word-serial AES key schedule (FIPS-197) supporting AES-128/192/256, selected per request. It accepts one cipher key over a valid/ready handshake and streams all Nr+1 round keys, 128 bits each, over a valid/yumi handshake with round index and last flag. It sits between the key-load interface and the round pipeline, and is the generalised successor of the fixed AES-256 single-step round key block.

---
 rtl/key_schedule_stream_if.sv | 28 ++
 rtl/key_schedule_stream.sv | 243 ++++++++++++++++++++++++
 tb/tb_key_schedule_stream.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_schedule_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : key_schedule_stream_if
// Brief    : key-request and round-key stream bundle for key_schedule_stream.
// Revision : 1.0
// ============================================================================
interface key_schedule_stream_if;
  logic           v_i;
  logic           ready_o;
  logic [0:255]   key_i;
  logic [1:0]     mode_i;
  logic           v_o;
  logic           yumi_i;
  logic [0:127]   rk_o;
  logic [3:0]     rnd_o;
  logic           last_o;

  modport slave (
    input  v_i, key_i, mode_i, yumi_i,
    output ready_o, v_o, rk_o, rnd_o, last_o
  );

  modport master (
    output v_i, key_i, mode_i, yumi_i,
    input  ready_o, v_o, rk_o, rnd_o, last_o
  );
endinterface
`default_nettype wire

// File: rtl/key_schedule_stream.sv
`default_nettype none
// ============================================================================
// Module   : key_schedule_stream
// Brief    : word-serial AES-128/192/256 key schedule streaming 128-bit round
//            keys; define KEY_SCHED_ABORT_EN to add the abort_i port.
// Revision : 1.0
// ============================================================================
module key_schedule_stream #(
  parameter int MAX_KEY_BITS = 256,
  parameter int RK_W         = 128
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
`ifdef KEY_SCHED_ABORT_EN
  input  logic                        abort_i,
`endif
  key_schedule_stream_if.slave        ks_if
);

  if (RK_W != 128) begin : g_rk_w_check
    $error("key_schedule_stream: RK_W must be 128");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_GEN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [0:2047] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return c_SBOX[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [0:255]  key_q, key_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [5:0]    idx_q, idx_d;
  logic [2:0]    kcnt_q, kcnt_d;
  logic [31:0]   win_q [8];
  logic [31:0]   win_d [8];
  logic [0:127]  rk_q, rk_d;
  logic          v_q, v_d;
  logic [3:0]    rnd_q, rnd_d;
  logic          last_q, last_d;

  logic [1:0]    w_mode_eff;
  logic [2:0]    w_nk_m1;
  logic [5:0]    w_last_idx;
  logic [31:0]   w_prev;
  logic [31:0]   w_sub_in;
  logic [31:0]   w_sub_out;
  logic [31:0]   w_temp;
  logic [31:0]   w_gen_word;
  logic [31:0]   w_push_word;
  logic          w_push;

  // Modes wider than MAX_KEY_BITS, and the reserved code 3, fall back to AES-128.
  always_comb begin
    w_mode_eff = 2'd0;
    if (ks_if.mode_i == 2'd1 && MAX_KEY_BITS >= 192) begin
      w_mode_eff = 2'd1;
    end else if (ks_if.mode_i == 2'd2 && MAX_KEY_BITS >= 256) begin
      w_mode_eff = 2'd2;
    end
  end

  always_comb begin
    case (mode_q)
      2'd1:    begin w_nk_m1 = 3'd5; w_last_idx = 6'd51; end
      2'd2:    begin w_nk_m1 = 3'd7; w_last_idx = 6'd59; end
      default: begin w_nk_m1 = 3'd3; w_last_idx = 6'd43; end
    endcase
  end

  // win_q[0] is W[i-1]; win_q[Nk-1] is W[i-Nk].
  assign w_prev   = win_q[0];
  assign w_sub_in = (kcnt_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign w_sub_out[8*b +: 8] = sbox(w_sub_in[8*b +: 8]);
  end

  always_comb begin
    w_temp = w_prev;
    if (kcnt_q == 3'd0) begin
      w_temp = w_sub_out ^ {rcon_q, 24'h0};
    end else if (mode_q == 2'd2 && kcnt_q == 3'd4) begin
      w_temp = w_sub_out;
    end
  end

  assign w_gen_word  = win_q[w_nk_m1] ^ w_temp;
  assign w_push_word = (state_q == S_LOAD) ? key_q[0:31] : w_gen_word;
  assign w_push      = ((state_q == S_LOAD) || (state_q == S_GEN)) &&
                       (!v_q || ks_if.yumi_i);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    idx_d   = idx_q;
    kcnt_d  = kcnt_q;
    win_d   = win_q;
    rk_d    = rk_q;
    v_d     = v_q;
    rnd_d   = rnd_q;
    last_d  = last_q;

    if (v_q && ks_if.yumi_i) begin
      v_d    = 1'b0;
      last_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (ks_if.v_i) begin
          key_d   = ks_if.key_i;
          mode_d  = w_mode_eff;
          rcon_d  = 8'h01;
          idx_d   = 6'd0;
          kcnt_d  = 3'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD, S_GEN: begin
        if (w_push) begin
          win_d[0] = w_push_word;
          for (int k = 1; k < 8; k++) begin
            win_d[k] = win_q[k-1];
          end
          case (idx_q[1:0])
            2'd0:    rk_d[0:31]   = w_push_word;
            2'd1:    rk_d[32:63]  = w_push_word;
            2'd2:    rk_d[64:95]  = w_push_word;
            default: rk_d[96:127] = w_push_word;
          endcase
          if (idx_q[1:0] == 2'd3) begin
            v_d    = 1'b1;
            rnd_d  = idx_q[5:2];
            last_d = (idx_q == w_last_idx);
          end
          idx_d  = idx_q + 6'd1;
          kcnt_d = (kcnt_q == w_nk_m1) ? 3'd0 : kcnt_q + 3'd1;
          if (state_q == S_LOAD) begin
            key_d = {key_q[32:255], 32'h0};
            if (kcnt_q == w_nk_m1) begin
              state_d = S_GEN;
            end
          end else begin
            if (kcnt_q == 3'd0) begin
              rcon_d = xtime(rcon_q);
            end
            if (idx_q == w_last_idx) begin
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (ks_if.yumi_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef KEY_SCHED_ABORT_EN
    if (abort_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      v_d     = 1'b0;
      last_d  = 1'b0;
      rk_d    = '0;
      for (int k = 0; k < 8; k++) begin
        win_d[k] = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      key_q   <= '0;
      rcon_q  <= 8'h00;
      idx_q   <= 6'd0;
      kcnt_q  <= 3'd0;
      for (int k = 0; k < 8; k++) begin
        win_q[k] <= '0;
      end
      rk_q    <= '0;
      v_q     <= 1'b0;
      rnd_q   <= 4'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      idx_q   <= idx_d;
      kcnt_q  <= kcnt_d;
      win_q   <= win_d;
      rk_q    <= rk_d;
      v_q     <= v_d;
      rnd_q   <= rnd_d;
      last_q  <= last_d;
    end
  end

  assign ks_if.ready_o = (state_q == S_IDLE);
  assign ks_if.v_o     = v_q;
  assign ks_if.rk_o    = rk_q;
  assign ks_if.rnd_o   = rnd_q;
  assign ks_if.last_o  = last_q;

endmodule
`default_nettype wire

// File: tb/tb_key_schedule_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_schedule_stream
// Brief    : randomized bench for key_schedule_stream against an array-based
//            FIPS-197 key expansion with a GF(2^8)-derived S-box.
// Revision : 1.0
// ============================================================================
module tb_key_schedule_stream;

  localparam logic [0:255] c_K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:255] c_K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [0:255] c_K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic clk = 1'b0;
  logic reset;
`ifdef KEY_SCHED_ABORT_EN
  logic abort;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sb     [256];
  logic [127:0] ref_rk [15];
  logic [127:0] got_rk [15];
  int           ref_nr;

  key_schedule_stream_if ks();

  key_schedule_stream #(
    .MAX_KEY_BITS (256),
    .RK_W         (128)
  ) u_dut (
    .clk_i   (clk),
    .reset_i (reset),
`ifdef KEY_SCHED_ABORT_EN
    .abort_i (abort),
`endif
    .ks_if   (ks.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box = affine transform of the multiplicative inverse in GF(2^8).
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] r;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
        if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      end
      s = inv;
      r = inv;
      for (int n = 0; n < 4; n++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sb[a] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [0:255] key, input logic [1:0] mode);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk;
    nk = (mode == 2'd1) ? 6 : (mode == 2'd2) ? 8 : 4;
    ref_nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4 * (ref_nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[32*i +: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk == 8 && i % 8 == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= ref_nr; r++) begin
      ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  // Returns at the negedge following the accepting edge T0.
  task automatic send_req(input logic [0:255] key, input logic [1:0] mode);
    int k;
    k = 0;
    while (!ks.ready_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!ks.ready_o) check_eq("ready_timeout", ks.ready_o, 1);
    ks.v_i    = 1'b1;
    ks.key_i  = key;
    ks.mode_i = mode;
    @(negedge clk);
    ks.v_i    = 1'b0;
  endtask

  // policy 0: yumi tied high; 1: random yumi; 2: 20-cycle stall at round 3
  task automatic run_key(input logic [0:255] key, input logic [1:0] mode,
                         input int policy, input bit pulse);
    int r, k, stall;
    bit done, prev_v, prev_y, y;
    logic [127:0] prev_rk;
    logic [3:0]   prev_rnd;
    logic [0:255] junk;
    model_expand(key, mode);
    for (int j = 0; j < 15; j++) got_rk[j] = '0;
    send_req(key, mode);
    r = 0; k = 0; stall = 0; done = 0; prev_v = 0; prev_y = 0;
    prev_rk = '0; prev_rnd = '0;
    while (!done && k < 600) begin
      if (prev_v && !prev_y) begin
        check_eq("hold_v", ks.v_o, 1);
        check_eq("hold_rk", ks.rk_o, prev_rk);
        check_eq("hold_rnd", ks.rnd_o, prev_rnd);
      end
      if (pulse && k == 10) begin
        for (int j = 0; j < 8; j++) junk[32*j +: 32] = $urandom;
        ks.key_i  = junk;
        ks.mode_i = 2'd2;
        ks.v_i    = 1'b1;
      end else begin
        ks.v_i = 1'b0;
      end
      case (policy)
        0: y = 1'b1;
        1: y = ($urandom_range(0, 3) != 0);
        default: begin
          if (ks.v_o && ks.rnd_o == 4'd3 && stall < 20) begin
            y = 1'b0;
            stall++;
          end else begin
            y = 1'b1;
          end
        end
      endcase
      ks.yumi_i = y;
      if (ks.v_o && y) begin
        check_eq("rk", ks.rk_o, ref_rk[r]);
        check_eq("rnd", ks.rnd_o, r);
        check_eq("last", ks.last_o, (r == ref_nr));
        if (policy == 0) check_eq("latency", k, 4 + 4 * r);
        got_rk[r] = ks.rk_o;
        if (ks.last_o || r == ref_nr) done = 1;
        r++;
      end
      prev_v = ks.v_o; prev_y = y; prev_rk = ks.rk_o; prev_rnd = ks.rnd_o;
      @(negedge clk);
      k++;
    end
    ks.yumi_i = 1'b0;
    ks.v_i    = 1'b0;
    if (!done) begin
      check_eq("timeout", 0, 1);
    end else begin
      check_eq("nkeys", r, ref_nr + 1);
      check_eq("ready_after", ks.ready_o, 1);
      check_eq("v_after", ks.v_o, 0);
    end
  endtask

  initial begin
    logic [0:255] rkey;
    ks.v_i = 1'b0; ks.yumi_i = 1'b0; ks.key_i = '0; ks.mode_i = 2'd0;
    reset = 1'b1;
`ifdef KEY_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    build_sbox();
    repeat (3) @(negedge clk);
    check_eq("rst_ready", ks.ready_o, 1);
    check_eq("rst_v", ks.v_o, 0);
    check_eq("rst_rk", ks.rk_o, 0);
    check_eq("rst_rnd", ks.rnd_o, 0);
    check_eq("rst_last", ks.last_o, 0);
    reset = 1'b0;
    @(negedge clk);

    run_key(c_K128, 2'd0, 0, 1'b1);
    check_eq("k128_r0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check_eq("k128_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check_eq("k128_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_key(c_K192, 2'd1, 0, 1'b0);
    check_eq("k192_r12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);

    run_key(c_K256, 2'd2, 0, 1'b0);
    check_eq("k256_r1", got_rk[1], 128'h1f352c073b6108d72d9810a30914dff4);
    check_eq("k256_r14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

    run_key(c_K128, 2'd0, 2, 1'b0);
    check_eq("bp_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check_eq("bp_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    send_req(c_K256, 2'd2);
    ks.yumi_i = 1'b1;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_v", ks.v_o, 0);
    check_eq("midrst_ready", ks.ready_o, 1);
    check_eq("midrst_rk", ks.rk_o, 0);
    reset = 1'b0;
    ks.yumi_i = 1'b0;
    @(negedge clk);
    check_eq("postrst_v", ks.v_o, 0);
    run_key(c_K128, 2'd0, 0, 1'b0);
    check_eq("postrst_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_key(c_K128, 2'd3, 1, 1'b1);
    check_eq("mode3_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef KEY_SCHED_ABORT_EN
    send_req(c_K256, 2'd2);
    ks.yumi_i = 1'b1;
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    ks.yumi_i = 1'b0;
    check_eq("abort_v", ks.v_o, 0);
    check_eq("abort_ready", ks.ready_o, 1);
    check_eq("abort_rk", ks.rk_o, 0);
    check_eq("abort_last", ks.last_o, 0);
    run_key(c_K192, 2'd1, 0, 1'b0);
`endif

    for (int t = 0; t < 6; t++) begin
      for (int j = 0; j < 8; j++) rkey[32*j +: 32] = $urandom;
      run_key(rkey, 2'($urandom_range(0, 3)), 1, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
